// File: rtl/mips_pkg.sv
// Shared encodings for the ID/EX issue stage: ALU control codes, ALUOp values
// and R-type function fields.
package mips_pkg;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ORI    = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;

   typedef struct packed {
      logic [2:0] code;
      logic       illegal;
   } alu_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_fwd_select.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB beats the latched register data;
// register 0 is never forwarded.
module fwd_select #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src_reg,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              exm_reg_write,
   input  logic [REG_AW-1:0] exm_dest,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] operand
);

   logic src_nonzero;

   assign src_nonzero = (src_reg != {REG_AW{1'b0}});

   // Priority select of the operand source
   always_comb begin
      operand = reg_data;
      if (src_nonzero && exm_reg_write && (exm_dest == src_reg)) begin
         operand = exm_result;
      end else if (src_nonzero && wb_reg_write && (wb_dest == src_reg)) begin
         operand = wb_result;
      end else begin
         operand = reg_data;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding the ALU: latches decoded fields, encodes ALU control and
// applies operand forwarding on the latched source registers.
module alu_issue_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_alu_src,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_reg_write,
   input  logic              stall,
   input  logic              flush,
   input  logic              exm_reg_write,
   input  logic [REG_AW-1:0] exm_dest,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_control,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_reg_write,
   output logic              ex_illegal
);

   function automatic alu_ctrl_t encode_ctrl(input logic [1:0] alu_op, input logic [5:0] funct);
      alu_ctrl_t c;
      c.code    = ALU_ADD;
      c.illegal = 1'b0;
      case (alu_op)
         ALUOP_MEM:    c.code = ALU_ADD;
         ALUOP_BRANCH: c.code = ALU_SUB;
         ALUOP_ORI:    c.code = ALU_OR;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: c.code = ALU_ADD;
               FUNCT_SUB: c.code = ALU_SUB;
               FUNCT_AND: c.code = ALU_AND;
               FUNCT_OR:  c.code = ALU_OR;
               default: begin
                  c.code    = ALU_ADD;
                  c.illegal = 1'b1;
               end
            endcase
         end
         default: c.code = ALU_ADD;
      endcase
      return c;
   endfunction

   logic              valid_r;
   logic              reg_write_r;
   logic [REG_AW-1:0] dest_r;
   logic [REG_AW-1:0] rs_r;
   logic [REG_AW-1:0] rt_r;
   logic [DATA_W-1:0] rs_data_r;
   logic [DATA_W-1:0] rt_data_r;
   logic [DATA_W-1:0] imm_r;
   logic              alu_src_r;
   alu_ctrl_t         ctrl_r;
   logic [DATA_W-1:0] fwd_rt;

   // Stage register: flush drops validity only, stall holds everything
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r     <= 1'b0;
         reg_write_r <= 1'b0;
         dest_r      <= {REG_AW{1'b0}};
         rs_r        <= {REG_AW{1'b0}};
         rt_r        <= {REG_AW{1'b0}};
         rs_data_r   <= {DATA_W{1'b0}};
         rt_data_r   <= {DATA_W{1'b0}};
         imm_r       <= {DATA_W{1'b0}};
         alu_src_r   <= 1'b0;
         ctrl_r      <= '{code: ALU_ADD, illegal: 1'b0};
      end else if (flush) begin
         valid_r     <= 1'b0;
         reg_write_r <= 1'b0;
      end else if (stall) begin
         valid_r     <= valid_r;
         reg_write_r <= reg_write_r;
      end else begin
         valid_r     <= id_valid;
         reg_write_r <= id_reg_write & id_valid;
         dest_r      <= id_dest;
         rs_r        <= id_rs;
         rt_r        <= id_rt;
         rs_data_r   <= id_rs_data;
         rt_data_r   <= id_rt_data;
         imm_r       <= id_imm;
         alu_src_r   <= id_alu_src;
         ctrl_r      <= encode_ctrl(id_alu_op, id_funct);
      end
   end

   fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
      .src_reg(rs_r), .reg_data(rs_data_r),
      .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
      .operand(alu_a)
   );

   fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
      .src_reg(rt_r), .reg_data(rt_data_r),
      .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
      .operand(fwd_rt)
   );

   assign alu_b        = alu_src_r ? imm_r : fwd_rt;
   assign alu_control  = ctrl_r.code;
   assign ex_illegal   = ctrl_r.illegal;
   assign ex_valid     = valid_r;
   assign ex_dest      = dest_r;
   assign ex_reg_write = reg_write_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against an abstract stage model, plus
// hand-computed directed expectations.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [1:0]  id_alu_op = 2'b00;
   logic [5:0]  id_funct = 6'd0;
   logic [31:0] id_rs_data = 32'd0, id_rt_data = 32'd0, id_imm = 32'd0;
   logic        id_alu_src = 1'b0;
   logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_dest = 5'd0;
   logic        id_reg_write = 1'b0, stall = 1'b0, flush = 1'b0;
   logic        exm_reg_write = 1'b0, wb_reg_write = 1'b0;
   logic [4:0]  exm_dest = 5'd0, wb_dest = 5'd0;
   logic [31:0] exm_result = 32'd0, wb_result = 32'd0;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_control;
   logic        ex_valid, ex_reg_write, ex_illegal;
   logic [4:0]  ex_dest;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   alu_issue_stage dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
      .id_funct(id_funct), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt),
      .id_dest(id_dest), .id_reg_write(id_reg_write), .stall(stall), .flush(flush),
      .exm_reg_write(exm_reg_write), .exm_dest(exm_dest), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_valid(ex_valid),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   // Abstract model of what the stage has captured
   bit          m_valid, m_rw, m_src, m_ill;
   int unsigned m_dest, m_rs, m_rt, m_code;
   longint unsigned m_rs_data, m_rt_data, m_imm;

   function automatic int unsigned want_code(input int unsigned op, input int unsigned fn, output bit ill);
      ill = 1'b0;
      if (op == 0) return 2;
      if (op == 1) return 6;
      if (op == 3) return 1;
      if (fn == 32) return 2;
      if (fn == 34) return 6;
      if (fn == 36) return 0;
      if (fn == 37) return 1;
      ill = 1'b1;
      return 2;
   endfunction

   function automatic longint unsigned operand(input int unsigned r, input longint unsigned data);
      if (r != 0 && exm_reg_write && exm_dest == r) return exm_result;
      if (r != 0 && wb_reg_write && wb_dest == r) return wb_result;
      return data;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid = 0; m_rw = 0; m_src = 0; m_ill = 0;
         m_dest = 0; m_rs = 0; m_rt = 0; m_code = 2;
         m_rs_data = 0; m_rt_data = 0; m_imm = 0;
      end else if (flush) begin
         m_valid = 0; m_rw = 0;
      end else if (!stall) begin
         m_valid = id_valid; m_rw = id_reg_write && id_valid;
         m_dest = id_dest; m_rs = id_rs; m_rt = id_rt; m_src = id_alu_src;
         m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
         m_code = want_code(id_alu_op, id_funct, m_ill);
      end
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("alu_a", alu_a, operand(m_rs, m_rs_data));
         chk("alu_b", alu_b, m_src ? m_imm : operand(m_rt, m_rt_data));
         chk("alu_control", alu_control, m_code);
         chk("ex_valid", ex_valid, m_valid);
         chk("ex_dest", ex_dest, m_dest);
         chk("ex_reg_write", ex_reg_write, m_rw);
         chk("ex_illegal", ex_illegal, m_ill);
      end
   end

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input bit v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input bit src, input logic [31:0] imm);
      id_valid = v; id_alu_op = op; id_funct = fn; id_rs = rs; id_rt = rt;
      id_rs_data = rsd; id_rt_data = rtd; id_alu_src = src; id_imm = imm;
      id_dest = 5'd7; id_reg_write = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      check_en = 1'b1;
      #1;
      chk("reset_valid", ex_valid, 0);
      chk("reset_ctrl", alu_control, 3'b010);
      chk("reset_a", alu_a, 0);
      chk("reset_b", alu_b, 0);

      set_op(1, 2'b10, 6'b100010, 5'd1, 5'd2, 32'd9, 32'd4, 0, 32'd0);
      next_edge();
      chk("sub_ctrl", alu_control, 3'b110);
      chk("sub_a", alu_a, 9);
      chk("sub_b", alu_b, 4);

      set_op(1, 2'b00, 6'd0, 5'd3, 5'd0, 32'd1, 32'd0, 0, 32'd0);
      exm_reg_write = 1'b1; exm_dest = 5'd3; exm_result = 32'hAA;
      wb_reg_write = 1'b1; wb_dest = 5'd3; wb_result = 32'hBB;
      next_edge();
      chk("fwd_exm", alu_a, 32'hAA);
      stall = 1'b1;
      exm_reg_write = 1'b0;
      #1 chk("fwd_wb", alu_a, 32'hBB);
      exm_reg_write = 1'b1; exm_dest = 5'd0; exm_result = 32'hFF;
      #1 chk("zero_guard", alu_b, 0);
      stall = 1'b0; wb_reg_write = 1'b0;

      set_op(1, 2'b10, 6'b100100, 5'd4, 5'd5, 32'd11, 32'd12, 0, 32'd0);
      stall = 1'b1; flush = 1'b1;
      next_edge();
      chk("flush_valid", ex_valid, 0);
      chk("flush_ctrl_hold", alu_control, 3'b010);
      flush = 1'b0;
      set_op(1, 2'b01, 6'd0, 5'd6, 5'd6, 32'd13, 32'd14, 0, 32'd0);
      next_edge();
      chk("stall_valid", ex_valid, 0);
      chk("stall_ctrl", alu_control, 3'b010);
      stall = 1'b0; exm_reg_write = 1'b0;

      set_op(1, 2'b10, 6'b101010, 5'd1, 5'd1, 32'd0, 32'd0, 0, 32'd0);
      next_edge();
      chk("illegal_ctrl", alu_control, 3'b010);
      chk("illegal_flag", ex_illegal, 1);
      set_op(1, 2'b11, 6'd0, 5'd1, 5'd2, 32'd3, 32'd4, 1, 32'h0F);
      next_edge();
      chk("ori_ctrl", alu_control, 3'b001);
      chk("ori_b", alu_b, 32'h0F);
      chk("ori_illegal", ex_illegal, 0);

      for (int i = 0; i < 400; i++) begin
         #1;
         id_valid = 1'($urandom_range(0, 3) != 0);
         id_alu_op = 2'($urandom);
         id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (6'b100000 | 6'($urandom_range(0, 5)));
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         id_dest = 5'($urandom); id_reg_write = 1'($urandom);
         id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
         id_alu_src = 1'($urandom);
         stall = 1'($urandom_range(0, 5) == 0); flush = 1'($urandom_range(0, 7) == 0);
         exm_reg_write = 1'($urandom); exm_dest = 5'($urandom_range(0, 3)); exm_result = $urandom;
         wb_reg_write = 1'($urandom); wb_dest = 5'($urandom_range(0, 3)); wb_result = $urandom;
         if (i == 200) begin
            exm_reg_write = 1'b0; wb_reg_write = 1'b0;
            reset_n = 1'b0;
            #1;
            chk("async_valid", ex_valid, 0);
            chk("async_ctrl", alu_control, 3'b010);
            chk("async_a", alu_a, 0);
            @(posedge clk);
            #1 reset_n = 1'b1;
         end
         @(posedge clk);
      end
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
